hdlc_rx_bitstream: RTL and testbench
====================================

Name: hdlc_rx_bitstream

Overview:
Receive-side bit-level front end of the HDLC controller, directly upstream of the Rx buffer/FCS stage. It samples the serial line and performs:
- flag and abort detection
- zero removal (de-stuffing)
- LSB-first byte assembly
- frame delimiting

It produces the Rx_* strobes the Rx status/buffer logic and the bound assertion checker consume.

Parameters:
STUFF_RUN, 5, consecutive de-stuffed 1s after which a following 0 is removed.
MIN_BYTES, 2, minimum complete bytes in a frame; fewer at closing flag gives Rx_FrameError.

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  synchronous, active-high reset
Rx  input  1  serial receive line, one bit per cycle
RxEN  input  1  receiver enable; low forces IDLE, window and counters held at reset values
Rx_FlagDetect  output  1  one-cycle pulse, flag 01111110 seen
Rx_AbortDetect  output  1  one-cycle pulse, 0 followed by seven 1s seen
Rx_ValidFrame  output  1  high while inside a frame
Rx_NewByte  output  1  one-cycle pulse, Rx_Data valid
Rx_Data  output  8  assembled byte, LSB first on the line; held until next byte
Rx_StartZeroDetect  output  1  one-cycle pulse when a stuffed 0 is removed
Rx_EoF  output  1  one-cycle pulse, end of frame
Rx_AbortSignal  output  1  one-cycle pulse, abort inside frame
Rx_FrameError  output  1  one-cycle pulse, coincident with Rx_EoF

Behaviour:
- Reset (Rst=1 at edge):
  - all outputs 0, Rx_Data=8'h00
  - 8-bit window = 8'hFF (no false match), ones counter=0, bit counter=0, byte counter=0, state IDLE
- Window: each edge shifts Rx in. The bit shifted out (8 cycles old) is the data-path bit.
- Match signals: flag_m and abort_m are combinational compares on the window (newest bit = last received).
- Detect latency:
  - last flag bit sampled at cycle t → window matches at t+1 → Rx_FlagDetect high at sample t+2
  - Rx_AbortDetect: identical timing, on the 7th 1
  - a continuous 1s run after an abort gives no further pulses
- Discard rule: on an edge where flag_m or abort_m is true, the exiting data-path bit is discarded (it is the first delimiter bit).
- FSM states: IDLE, OPEN, FRAME.
  - IDLE → OPEN on flag_m.
  - OPEN: consume data bits.
    - flag_m clears counters and stays in OPEN (back-to-back or shared flags).
    - abort_m → IDLE.
    - 8 data bits consumed without flag_m → FRAME: Rx_ValidFrame rises on that edge and the first byte is emitted.
  - FRAME, flag_m (closing flag):
    - Rx_ValidFrame falls on that edge; Rx_EoF pulses the following cycle.
    - Rx_FrameError pulses with Rx_EoF if bit counter≠0 or byte counter<MIN_BYTES.
    - next state OPEN (closing flag may open the next frame).
  - FRAME, abort_m:
    - Rx_ValidFrame falls; Rx_AbortSignal and Rx_EoF pulse the next cycle; Rx_FrameError=0.
    - next state IDLE.
- Data path (OPEN/FRAME only):
  - ones counter counts consecutive consumed 1s, saturating at STUFF_RUN.
  - a 0 arriving with counter==STUFF_RUN is dropped: Rx_StartZeroDetect pulses, counter clears.
  - any other bit shifts into Rx_Data bit[bitcnt], bitcnt increments mod 8.
  - bitcnt wrap → Rx_NewByte pulse; byte counter increments, saturating at 255.
  - a 1 with counter==STUFF_RUN is consumed as data (it is a delimiter, caught by flag_m/abort_m).
- Precedence on the same edge: Rst > !RxEN > abort_m > flag_m > data.
- RxEN low in FRAME: Rx_ValidFrame drops, Rx_AbortSignal and Rx_EoF pulse next cycle, state IDLE.
- Rx_NewByte never coincides with a delimiter edge.

Optional Feature:
HDLC_RX_INSYNC_EN:
- Defined: Rx passes through a two-flop synchronizer (reset value 1) before the window. All Rx-relative latencies +2 (Rx_FlagDetect at t+4).
- Undefined: Rx goes directly into the window; latencies as above.

Test Plan:
- Idle 1s for 20 cycles, then 01111110 → single Rx_FlagDetect pulse at t+2; Rx_ValidFrame stays 0; no Rx_AbortDetect.
- Flag, bytes 8'hA5, 8'h3C, flag → Rx_NewByte twice with Rx_Data=8'hA5 then 8'h3C; Rx_ValidFrame falls with the second Rx_FlagDetect; Rx_EoF next cycle; Rx_FrameError=0.
- Flag, byte 8'hFF stuffed on line (11111 0 111), byte 8'h00, flag → Rx_StartZeroDetect pulse once; Rx_Data=8'hFF then 8'h00; no error.
- Flag, 8'h12, 8'h34, then 01111111 → Rx_AbortDetect at t+2; Rx_ValidFrame falls the same cycle; Rx_AbortSignal and Rx_EoF the next; no Rx_FrameError.
- Flag, 8'h12, 3 extra bits 101, flag → Rx_EoF with Rx_FrameError=1. Flag, single 8'h55, flag → Rx_FrameError=1 (MIN_BYTES=2).
- Rst asserted mid-frame after 4 bits → next cycle all outputs 0; a subsequent flag and 8'h81 and flag frame are received correctly.

Source files
------------

// File: rtl/hdlc_rx_bitstream_if.sv
// ---------------------------------------------------------------------------
// hdlc_rx_bitstream_if
//   Bundles the serial receive line, the receiver enable and the Rx_* strobes
//   produced by the HDLC receive bit-level front end.
//
//   master : line/consumer side  (drives Rx, RxEN; observes the strobes)
//   slave  : hdlc_rx_bitstream   (samples Rx, RxEN; drives the strobes)
//
//   Rx                 serial receive line, one bit per clock
//   RxEN               receiver enable
//   Rx_FlagDetect      pulse, flag 01111110 seen
//   Rx_AbortDetect     pulse, 0 followed by seven 1s seen
//   Rx_ValidFrame      level, inside a frame
//   Rx_NewByte         pulse, Rx_Data valid
//   Rx_Data[7:0]       assembled byte, held until the next byte
//   Rx_StartZeroDetect pulse, a stuffed zero was removed
//   Rx_EoF             pulse, end of frame
//   Rx_AbortSignal     pulse, abort inside a frame
//   Rx_FrameError      pulse, coincident with Rx_EoF
// ---------------------------------------------------------------------------
interface hdlc_rx_bitstream_if;
  logic       Rx;
  logic       RxEN;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic       Rx_NewByte;
  logic [7:0] Rx_Data;
  logic       Rx_StartZeroDetect;
  logic       Rx_EoF;
  logic       Rx_AbortSignal;
  logic       Rx_FrameError;

  modport master (
    output Rx, RxEN,
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte, Rx_Data,
           Rx_StartZeroDetect, Rx_EoF, Rx_AbortSignal, Rx_FrameError
  );

  modport slave (
    input  Rx, RxEN,
    output Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte, Rx_Data,
           Rx_StartZeroDetect, Rx_EoF, Rx_AbortSignal, Rx_FrameError
  );
endinterface

// File: rtl/hdlc_rx_bitstream.sv
// ---------------------------------------------------------------------------
// hdlc_rx_bitstream
//   Receive-side bit-level front end of the HDLC controller. Samples the
//   serial line into an 8-bit window, detects flags and aborts on the window,
//   removes stuffed zeros from the bit leaving the window, assembles bytes
//   LSB first and delimits frames for the downstream Rx buffer/FCS stage.
//
// Ports
//   Clk   : clock, all logic on the rising edge
//   Rst   : synchronous active-high reset
//   bus   : hdlc_rx_bitstream_if.slave (Rx, RxEN in; Rx_* strobes out)
//
// Parameters
//   STUFF_RUN : consecutive 1s after which a following 0 is removed
//   MIN_BYTES : minimum complete bytes in a frame before the closing flag
//
// Optional feature
//   HDLC_RX_INSYNC_EN : when defined, Rx passes through a two-flop
//                       synchronizer (reset value 1) ahead of the window,
//                       adding two cycles to every Rx-relative latency.
// ---------------------------------------------------------------------------
module hdlc_rx_bitstream #(
  parameter int STUFF_RUN = 5,
  parameter int MIN_BYTES = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  hdlc_rx_bitstream_if.slave bus
);

  localparam int                ONES_W   = $clog2(STUFF_RUN + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_RUN);
  localparam logic [7:0]        MIN_CNT  = 8'(MIN_BYTES);
  localparam logic [7:0]        FLAG_PAT = 8'b0111_1110;
  localparam logic [7:0]        ABRT_PAT = 8'b0111_1111;

  typedef enum logic [1:0] {IDLE, OPEN, FRAME} state_t;

  logic w_rxIn;

`ifdef HDLC_RX_INSYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge Clk) begin
    if (Rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], bus.Rx};
  end

  assign w_rxIn = r_sync[1];
`else
  assign w_rxIn = bus.Rx;
`endif

  state_t            r_state,    w_nxtState;
  logic [7:0]        r_win,      w_nxtWin;
  logic [ONES_W-1:0] r_ones,     w_nxtOnes;
  logic [2:0]        r_bitCnt,   w_nxtBitCnt;
  logic [7:0]        r_byteCnt,  w_nxtByteCnt;
  logic [6:0]        r_shift,    w_nxtShift;
  logic [2:0]        r_skip,     w_nxtSkip;
  logic              r_valid,    w_nxtValid;
  logic [7:0]        r_data,     w_nxtData;
  logic              r_newByte,  w_nxtNewByte;
  logic              r_zeroDet,  w_nxtZeroDet;
  logic              r_eofPend,  w_nxtEofPend;
  logic              r_errPend,  w_nxtErrPend;
  logic              r_abtPend,  w_nxtAbtPend;
  logic              r_flagDet;
  logic              r_abortDet;
  logic              r_eof;
  logic              r_frameErr;
  logic              r_abortSig;

  logic w_flagM;
  logic w_abortM;
  logic w_outBit;

  // Newest bit sits in r_win[0]; the oldest (r_win[7]) is the data-path bit.
  assign w_flagM  = (r_win == FLAG_PAT);
  assign w_abortM = (r_win == ABRT_PAT);
  assign w_outBit = r_win[7];

  // Next-state and datapath decisions in priority order:
  // disable/abort, then flag, then ordinary data.
  always_comb begin
    w_nxtState   = r_state;
    w_nxtWin     = {r_win[6:0], w_rxIn};
    w_nxtOnes    = r_ones;
    w_nxtBitCnt  = r_bitCnt;
    w_nxtByteCnt = r_byteCnt;
    w_nxtShift   = r_shift;
    w_nxtSkip    = (r_skip != 3'd0) ? r_skip - 3'd1 : 3'd0;
    w_nxtValid   = r_valid;
    w_nxtData    = r_data;
    w_nxtNewByte = 1'b0;
    w_nxtZeroDet = 1'b0;
    w_nxtEofPend = 1'b0;
    w_nxtErrPend = 1'b0;
    w_nxtAbtPend = 1'b0;

    if (!bus.RxEN || w_abortM) begin
      // Disabling the receiver inside a frame ends it like an abort.
      if (!bus.RxEN) w_nxtWin = 8'hFF;
      w_nxtState   = IDLE;
      w_nxtOnes    = '0;
      w_nxtBitCnt  = 3'd0;
      w_nxtByteCnt = 8'd0;
      w_nxtSkip    = 3'd0;
      w_nxtValid   = 1'b0;
      if (r_state == FRAME) begin
        w_nxtEofPend = 1'b1;
        w_nxtAbtPend = 1'b1;
      end
    end else if (w_flagM) begin
      if (r_state == FRAME) begin
        w_nxtValid   = 1'b0;
        w_nxtEofPend = 1'b1;
        w_nxtErrPend = (r_bitCnt != 3'd0) || (r_byteCnt < MIN_CNT);
      end
      w_nxtState   = OPEN;
      w_nxtOnes    = '0;
      w_nxtBitCnt  = 3'd0;
      w_nxtByteCnt = 8'd0;
      // The remaining seven flag bits still have to leave the window and
      // must not be mistaken for frame data.
      w_nxtSkip    = 3'd7;
    end else if ((r_state != IDLE) && (r_skip == 3'd0)) begin
      if (!w_outBit && (r_ones == ONES_MAX)) begin
        w_nxtZeroDet = 1'b1;
        w_nxtOnes    = '0;
      end else begin
        if (w_outBit) w_nxtOnes = (r_ones == ONES_MAX) ? r_ones : r_ones + ONES_W'(1);
        else          w_nxtOnes = '0;
        w_nxtShift  = {w_outBit, r_shift[6:1]};
        w_nxtBitCnt = r_bitCnt + 3'd1;
        if (r_bitCnt == 3'd7) begin
          w_nxtNewByte = 1'b1;
          w_nxtData    = {w_outBit, r_shift};
          w_nxtByteCnt = (r_byteCnt != 8'hFF) ? r_byteCnt + 8'd1 : r_byteCnt;
          if (r_state == OPEN) begin
            w_nxtState = FRAME;
            w_nxtValid = 1'b1;
          end
        end
      end
    end
  end

  // Frame-end strobes are staged one cycle so they follow the falling
  // edge of Rx_ValidFrame.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_win      <= 8'hFF;
      r_ones     <= '0;
      r_bitCnt   <= 3'd0;
      r_byteCnt  <= 8'd0;
      r_shift    <= 7'd0;
      r_skip     <= 3'd0;
      r_valid    <= 1'b0;
      r_data     <= 8'h00;
      r_newByte  <= 1'b0;
      r_zeroDet  <= 1'b0;
      r_eofPend  <= 1'b0;
      r_errPend  <= 1'b0;
      r_abtPend  <= 1'b0;
      r_flagDet  <= 1'b0;
      r_abortDet <= 1'b0;
      r_eof      <= 1'b0;
      r_frameErr <= 1'b0;
      r_abortSig <= 1'b0;
    end else begin
      r_state    <= w_nxtState;
      r_win      <= w_nxtWin;
      r_ones     <= w_nxtOnes;
      r_bitCnt   <= w_nxtBitCnt;
      r_byteCnt  <= w_nxtByteCnt;
      r_shift    <= w_nxtShift;
      r_skip     <= w_nxtSkip;
      r_valid    <= w_nxtValid;
      r_data     <= w_nxtData;
      r_newByte  <= w_nxtNewByte;
      r_zeroDet  <= w_nxtZeroDet;
      r_eofPend  <= w_nxtEofPend;
      r_errPend  <= w_nxtErrPend;
      r_abtPend  <= w_nxtAbtPend;
      r_flagDet  <= bus.RxEN & w_flagM;
      r_abortDet <= bus.RxEN & w_abortM;
      r_eof      <= r_eofPend;
      r_frameErr <= r_errPend;
      r_abortSig <= r_abtPend;
    end
  end

  assign bus.Rx_FlagDetect      = r_flagDet;
  assign bus.Rx_AbortDetect     = r_abortDet;
  assign bus.Rx_ValidFrame      = r_valid;
  assign bus.Rx_NewByte         = r_newByte;
  assign bus.Rx_Data            = r_data;
  assign bus.Rx_StartZeroDetect = r_zeroDet;
  assign bus.Rx_EoF             = r_eof;
  assign bus.Rx_AbortSignal     = r_abortSig;
  assign bus.Rx_FrameError      = r_frameErr;

endmodule

// File: tb/tb_hdlc_rx_bitstream.sv
// ---------------------------------------------------------------------------
// tb_hdlc_rx_bitstream
//   Self-checking bench for hdlc_rx_bitstream. Frames are built from byte
//   payloads, zero-stuffed by a transmitter model and wrapped in flags or an
//   abort; a negedge monitor scores every Rx_NewByte / Rx_EoF against queues
//   of expected bytes and frame endings. Timing-sensitive corner cases are
//   checked cycle by cycle in hand-written sequences.
// ---------------------------------------------------------------------------
module tb_hdlc_rx_bitstream;

  localparam int MIN_BYTES = 2;

  logic Clk = 1'b0;
  logic Rst;

  always #5 Clk = ~Clk;

  hdlc_rx_bitstream_if bus ();

  hdlc_rx_bitstream #(
    .STUFF_RUN (5),
    .MIN_BYTES (MIN_BYTES)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int onesRun = 0;
  int zerosSent = 0;
  int zerosSeen = 0;

  logic [7:0] expBytes[$];
  logic [1:0] expEnds[$];

  typedef struct {
    logic [31:0] payload;
    int          nBytes;
    logic [7:0]  extra;
    int          extraLen;
    bit          endAbort;
    bit          expErr;
    bit          expAbt;
    int          expZeros;
  } vec_t;

  vec_t vecs[6];

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
  endtask

  // Drive one line bit; returns 1ns after the edge that sampled it.
  task automatic applyStimulus(input logic b);
    bus.Rx = b;
    @(posedge Clk);
    #1;
  endtask

  task automatic sendRaw(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) applyStimulus(v[i]);
  endtask

  task automatic sendFlag();
    sendRaw(8'h7E, 8);
    onesRun = 0;
  endtask

  // Line order: 0 then seven 1s.
  task automatic sendAbort();
    sendRaw(8'hFE, 8);
    onesRun = 0;
  endtask

  // Transmitter model: LSB first, a 0 inserted after every five data 1s.
  task automatic sendData(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(v[i]);
      if (v[i]) begin
        onesRun++;
        if (onesRun == 5) begin
          applyStimulus(1'b0);
          onesRun = 0;
          zerosSent++;
        end
      end else begin
        onesRun = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1);
  endtask

  task automatic sendFrame(input logic [31:0] payload, input int nBytes,
                           input logic [7:0] extra, input int extraLen,
                           input bit endAbort, input bit expErr, input bit expAbt);
    for (int b = 0; b < nBytes; b++) expBytes.push_back(payload[8*b +: 8]);
    if (nBytes > 0) expEnds.push_back({expErr, expAbt});
    sendFlag();
    for (int b = 0; b < nBytes; b++) sendData(payload[8*b +: 8], 8);
    if (extraLen > 0) sendData(extra, extraLen);
    if (endAbort) sendAbort();
    else          sendFlag();
  endtask

  function automatic logic [15:0] outVec();
    return {bus.Rx_FlagDetect, bus.Rx_AbortDetect, bus.Rx_ValidFrame,
            bus.Rx_NewByte, bus.Rx_StartZeroDetect, bus.Rx_EoF,
            bus.Rx_AbortSignal, bus.Rx_FrameError, bus.Rx_Data};
  endfunction

  // Scoreboard: every byte and every frame end must be one that was sent.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (bus.Rx_NewByte) begin
        checkOutput("newbyte_off_delim", {30'd0, bus.Rx_FlagDetect, bus.Rx_AbortDetect}, 32'd0);
        checkOutput("newbyte_expected", 32'(expBytes.size() != 0), 32'd1);
        if (expBytes.size() != 0) checkOutput("rx_data", 32'(bus.Rx_Data), 32'(expBytes.pop_front()));
      end
      if (bus.Rx_EoF) begin
        checkOutput("eof_expected", 32'(expEnds.size() != 0), 32'd1);
        if (expEnds.size() != 0) begin
          logic [1:0] e;
          e = expEnds.pop_front();
          checkOutput("frame_error", 32'(bus.Rx_FrameError), 32'(e[1]));
          checkOutput("abort_signal", 32'(bus.Rx_AbortSignal), 32'(e[0]));
        end
      end
      if (bus.Rx_FrameError) checkOutput("error_with_eof", 32'(bus.Rx_EoF), 32'd1);
      if (bus.Rx_StartZeroDetect) zerosSeen++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int z0;
    vecs[0] = '{32'h0000_3CA5, 2, 8'h00, 0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{32'h0000_00FF, 2, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{32'h0000_3412, 2, 8'h00, 0, 1'b1, 1'b0, 1'b1, 0};
    vecs[3] = '{32'h0000_0012, 1, 8'h05, 3, 1'b0, 1'b1, 1'b0, 0};
    vecs[4] = '{32'h0000_0055, 1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{32'h00FF_FF7E, 3, 8'h00, 0, 1'b0, 1'b0, 1'b0, 4};

    bus.Rx   = 1'b1;
    bus.RxEN = 1'b0;
    Rst      = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset_outputs", 32'(outVec()), 32'd0);
    Rst      = 1'b0;
    bus.RxEN = 1'b1;

    // Idle line then a lone flag: one detect pulse, no frame, no abort.
    idle(20);
    sendFlag();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1);
      checkOutput("flag_pulse", 32'(bus.Rx_FlagDetect), 32'(k == 0));
      checkOutput("lone_flag_valid", 32'(bus.Rx_ValidFrame), 32'd0);
      checkOutput("lone_flag_abort", 32'(bus.Rx_AbortDetect), 32'd0);
    end
    bus.RxEN = 1'b0;
    applyStimulus(1'b1);
    bus.RxEN = 1'b1;
    idle(4);

    // A5, 3C frame: closing flag timing.
    expBytes.push_back(8'hA5);
    expBytes.push_back(8'h3C);
    expEnds.push_back(2'b00);
    sendFlag();
    sendData(8'hA5, 8);
    sendData(8'h3C, 8);
    sendFlag();
    checkOutput("valid_before_close", 32'(bus.Rx_ValidFrame), 32'd1);
    applyStimulus(1'b1);
    checkOutput("close_flag_detect", 32'(bus.Rx_FlagDetect), 32'd1);
    checkOutput("close_valid_fall", 32'(bus.Rx_ValidFrame), 32'd0);
    checkOutput("close_eof_early", 32'(bus.Rx_EoF), 32'd0);
    applyStimulus(1'b1);
    checkOutput("close_eof", 32'(bus.Rx_EoF), 32'd1);
    checkOutput("close_no_error", 32'(bus.Rx_FrameError), 32'd0);
    idle(12);

    // 12, 34 then abort: abort timing and no repeat detects on the 1s run.
    expBytes.push_back(8'h12);
    expBytes.push_back(8'h34);
    expEnds.push_back(2'b01);
    sendFlag();
    sendData(8'h12, 8);
    sendData(8'h34, 8);
    sendAbort();
    checkOutput("valid_before_abort", 32'(bus.Rx_ValidFrame), 32'd1);
    applyStimulus(1'b1);
    checkOutput("abort_detect", 32'(bus.Rx_AbortDetect), 32'd1);
    checkOutput("abort_valid_fall", 32'(bus.Rx_ValidFrame), 32'd0);
    checkOutput("abort_signal_early", 32'(bus.Rx_AbortSignal), 32'd0);
    applyStimulus(1'b1);
    checkOutput("abort_signal", 32'(bus.Rx_AbortSignal), 32'd1);
    checkOutput("abort_eof", 32'(bus.Rx_EoF), 32'd1);
    checkOutput("abort_no_error", 32'(bus.Rx_FrameError), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1);
      checkOutput("abort_no_repeat", 32'(bus.Rx_AbortDetect), 32'd0);
    end
    idle(4);

    // Reset mid-frame, then a clean one-byte frame (short, so it errors).
    sendFlag();
    sendRaw(8'h05, 4);
    Rst = 1'b1;
    applyStimulus(1'b1);
    checkOutput("midframe_reset", 32'(outVec()), 32'd0);
    Rst = 1'b0;
    onesRun = 0;
    sendFrame(32'h0000_0081, 1, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    idle(12);
    checkOutput("after_reset_bytes_left", 32'(expBytes.size()), 32'd0);
    checkOutput("after_reset_ends_left", 32'(expEnds.size()), 32'd0);

    // Frame-level vector table.
    for (int i = 0; i < 6; i++) begin
      z0 = zerosSeen;
      sendFrame(vecs[i].payload, vecs[i].nBytes, vecs[i].extra, vecs[i].extraLen,
                vecs[i].endAbort, vecs[i].expErr, vecs[i].expAbt);
      idle(12);
      checkOutput($sformatf("vec%0d_zeros", i), 32'(zerosSeen - z0), 32'(vecs[i].expZeros));
      checkOutput($sformatf("vec%0d_bytes_left", i), 32'(expBytes.size()), 32'd0);
      checkOutput($sformatf("vec%0d_ends_left", i), 32'(expEnds.size()), 32'd0);
    end

    // Randomized frames against the transmitter model.
    zerosSent = 0;
    zerosSeen = 0;
    for (int f = 0; f < 30; f++) begin
      logic [31:0] pay;
      int          nb;
      int          xl;
      bit          ab;
      pay = $urandom;
      nb  = $urandom_range(1, 4);
      ab  = ($urandom_range(0, 4) == 0);
      xl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      sendFrame(pay, nb, 8'($urandom), xl, ab,
                !ab && ((xl != 0) || (nb < MIN_BYTES)), ab);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(9, 15));
    end
    idle(20);
    checkOutput("random_zeros", 32'(zerosSeen), 32'(zerosSent));
    checkOutput("random_bytes_left", 32'(expBytes.size()), 32'd0);
    checkOutput("random_ends_left", 32'(expEnds.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
